time_base_controller: RTL and testbench

Owns the alarm clock's single time base. It divides `i_Clk` into one-cycle clock-enable ticks (1 Hz timekeeping, display scan, blink) rather than derived clocks. It sequences the HH:MM:SS timekeeping registers and arbitrates between free-running advance and user set mode. It sits between the board clock and the display mux, alarm comparator and button front end, all of which consume its ticks and time outputs.

---
 rtl/time_base_controller_pkg.sv | 30 +++
 rtl/time_base_controller_tick_gen.sv | 38 +++
 rtl/time_base_controller.sv | 127 ++++++++++++
 tb/tb_time_base_controller.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_base_controller_pkg.sv
// Shared definitions for the alarm clock time base: set-mode encodings,
// FSM state type, time field limits and widths.
package time_base_controller_pkg;

  localparam logic [1:0] MODE_RUN     = 2'b00;
  localparam logic [1:0] MODE_SET_HR  = 2'b01;
  localparam logic [1:0] MODE_SET_MIN = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_t;

  localparam int unsigned HOURS_LIMIT  = 24;
  localparam int unsigned MINSEC_LIMIT = 60;
  localparam int unsigned HOURS_W      = 5;
  localparam int unsigned MINSEC_W     = 6;

  // Mode 11 is not a set mode and falls back to RUN.
  function automatic state_t mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_SET_HR:  return ST_SET_HR;
      MODE_SET_MIN: return ST_SET_MIN;
      MODE_RUN:     return ST_RUN;
      default:      return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/time_base_controller_tick_gen.sv
// tick_gen: free-running divide-by-P counter producing a registered
// one-cycle tick in the cycle after the counter reaches P-1.
// Ports:
//   i_Clk   - system clock
//   i_Reset - synchronous active-high reset
//   i_Clear - synchronous clear/hold of counter and tick
//   o_Tick  - one-cycle pulse every P cycles
module tick_gen #(
  parameter int unsigned P = 2
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] LAST = CW'(P - 1);

  logic [CW-1:0] r_Count;
  logic          r_Tick;
  logic          w_Last;

  assign w_Last = (r_Count == LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear) begin
      r_Count <= '0;
      r_Tick  <= 1'b0;
    end else begin
      r_Tick  <= w_Last;
      r_Count <= w_Last ? '0 : r_Count + CW'(1);
    end
  end

  assign o_Tick = r_Tick;

endmodule

// File: rtl/time_base_controller.sv
// time_base_controller: single time base for the alarm clock. Derives the
// 1 Hz, display-scan and blink clock enables from i_Clk and sequences the
// HH:MM:SS binary counters under a RUN / SET_HR / SET_MIN FSM.
// Ports:
//   i_Clk, i_Reset  - clock, synchronous active-high reset
//   i_Set_Mode[1:0] - 00 run, 01 set hours, 10 set minutes, 11 run
//   i_Inc           - one-cycle increment pulse for the selected field
//   o_Hours/o_Minutes/o_Seconds - current time (binary)
//   o_Tick_1Hz, o_Tick_Scan     - one-cycle enables
//   o_Blink         - 50% square wave at BLINK_HZ
//   o_Setting       - high while in a set state
module time_base_controller
  import time_base_controller_pkg::*;
#(
  parameter int unsigned CLK_IN   = 100000000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic [1:0]          i_Set_Mode,
  input  logic                i_Inc,
  output logic [HOURS_W-1:0]  o_Hours,
  output logic [MINSEC_W-1:0] o_Minutes,
  output logic [MINSEC_W-1:0] o_Seconds,
  output logic                o_Tick_1Hz,
  output logic                o_Tick_Scan,
  output logic                o_Blink,
  output logic                o_Setting
);

  generate
    if ((CLK_IN % SCAN_HZ) != 0 || (CLK_IN % (2 * BLINK_HZ)) != 0) begin : g_bad_div
      $error("time_base_controller: CLK_IN must be divisible by SCAN_HZ and 2*BLINK_HZ");
    end
  endgenerate

  state_t              r_State;
  state_t              w_Next_State;
  logic [HOURS_W-1:0]  r_Hours;
  logic [MINSEC_W-1:0] r_Minutes;
  logic [MINSEC_W-1:0] r_Seconds;
  logic                r_Blink;

  logic w_Tick_1Hz, w_Tick_Scan, w_Tick_Blink;
  logic w_Hold_1Hz, w_Enter_Set;
  logic w_Sec_Last, w_Min_Last, w_Hr_Last;
  logic [HOURS_W-1:0]  w_Hours_Next;
  logic [MINSEC_W-1:0] w_Minutes_Next;

  assign w_Next_State = mode_to_state(i_Set_Mode);
  assign w_Enter_Set  = (r_State == ST_RUN) && (w_Next_State != ST_RUN);
  // Holding the 1 Hz divider on the next state (not the current one) clears
  // it on the entry edge itself, so a tick coinciding with entry is discarded.
  assign w_Hold_1Hz   = (w_Next_State != ST_RUN);

  tick_gen #(.P(CLK_IN)) u_tick_1hz (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Clear (w_Hold_1Hz),
    .o_Tick  (w_Tick_1Hz)
  );

  tick_gen #(.P(CLK_IN / SCAN_HZ)) u_tick_scan (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Clear (1'b0),
    .o_Tick  (w_Tick_Scan)
  );

  tick_gen #(.P(CLK_IN / (2 * BLINK_HZ))) u_tick_blink (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Clear (1'b0),
    .o_Tick  (w_Tick_Blink)
  );

  assign w_Sec_Last     = (r_Seconds == MINSEC_W'(MINSEC_LIMIT - 1));
  assign w_Min_Last     = (r_Minutes == MINSEC_W'(MINSEC_LIMIT - 1));
  assign w_Hr_Last      = (r_Hours == HOURS_W'(HOURS_LIMIT - 1));
  assign w_Hours_Next   = w_Hr_Last  ? '0 : r_Hours + HOURS_W'(1);
  assign w_Minutes_Next = w_Min_Last ? '0 : r_Minutes + MINSEC_W'(1);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State   <= ST_RUN;
      r_Hours   <= '0;
      r_Minutes <= '0;
      r_Seconds <= '0;
      r_Blink   <= 1'b0;
    end else begin
      r_State <= w_Next_State;
      if (w_Tick_Blink) r_Blink <= ~r_Blink;

      // Entry from RUN takes priority over a coincident 1 Hz advance.
      if (w_Enter_Set) begin
        r_Seconds <= '0;
      end else begin
        case (r_State)
          ST_RUN: begin
            if (w_Tick_1Hz) begin
              if (w_Sec_Last) begin
                r_Seconds <= '0;
                r_Minutes <= w_Minutes_Next;
                if (w_Min_Last) r_Hours <= w_Hours_Next;
              end else begin
                r_Seconds <= r_Seconds + MINSEC_W'(1);
              end
            end
          end
          ST_SET_HR:  if (i_Inc) r_Hours   <= w_Hours_Next;
          ST_SET_MIN: if (i_Inc) r_Minutes <= w_Minutes_Next;
          default: ;
        endcase
      end
    end
  end

  assign o_Hours     = r_Hours;
  assign o_Minutes   = r_Minutes;
  assign o_Seconds   = r_Seconds;
  assign o_Tick_1Hz  = w_Tick_1Hz;
  assign o_Tick_Scan = w_Tick_Scan;
  assign o_Blink     = r_Blink;
  assign o_Setting   = (r_State != ST_RUN);

endmodule

// File: tb/tb_time_base_controller.sv
// Self-checking bench for time_base_controller with a time-of-day
// reference model kept as seconds-of-day arithmetic.
module tb_time_base_controller;

  localparam int CLK_IN   = 1000;
  localparam int SCAN_HZ  = 100;
  localparam int BLINK_HZ = 2;
  localparam int SCAN_P   = CLK_IN / SCAN_HZ;
  localparam int BLINK_P  = CLK_IN / (2 * BLINK_HZ);

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Inc = 1'b0;
  logic [1:0] i_Set_Mode = 2'b00;
  logic [4:0] o_Hours;
  logic [5:0] o_Minutes, o_Seconds;
  logic       o_Tick_1Hz, o_Tick_Scan, o_Blink, o_Setting;

  always #5 i_Clk = ~i_Clk;

  time_base_controller #(
    .CLK_IN   (CLK_IN),
    .SCAN_HZ  (SCAN_HZ),
    .BLINK_HZ (BLINK_HZ)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Set_Mode  (i_Set_Mode),
    .i_Inc       (i_Inc),
    .o_Hours     (o_Hours),
    .o_Minutes   (o_Minutes),
    .o_Seconds   (o_Seconds),
    .o_Tick_1Hz  (o_Tick_1Hz),
    .o_Tick_Scan (o_Tick_Scan),
    .o_Blink     (o_Blink),
    .o_Setting   (o_Setting)
  );

  int total = 0;
  int bad = 0;

  // Reference model: mode 0 run, 1 set hours, 2 set minutes.
  int m_state = 0, m_secday = 0, m_run = 0, m_cyc = 0;
  bit e_tick = 0, e_scan = 0, e_blink = 0, e_setting = 0;

  task automatic model_edge();
    int nxt, h, mi, s, t;
    h = m_secday / 3600; mi = (m_secday / 60) % 60; s = m_secday % 60;
    if (i_Reset) begin
      m_state = 0; m_secday = 0; m_run = 0; m_cyc = 0;
      e_tick = 0; e_scan = 0; e_blink = 0; e_setting = 0;
    end else begin
      nxt = (i_Set_Mode == 2'b01) ? 1 : (i_Set_Mode == 2'b10) ? 2 : 0;
      if (m_state == 0 && nxt != 0) s = 0;
      else if (m_state == 0 && e_tick) begin
        t = (m_secday + 1) % 86400;
        h = t / 3600; mi = (t / 60) % 60; s = t % 60;
      end
      else if (m_state == 1 && i_Inc) h = (h + 1) % 24;
      else if (m_state == 2 && i_Inc) mi = (mi + 1) % 60;
      m_secday  = h * 3600 + mi * 60 + s;
      m_state   = nxt;
      e_setting = (nxt != 0);
      m_cyc++;
      e_scan  = (m_cyc % SCAN_P) == 0;
      e_blink = (((m_cyc - 1) / BLINK_P) % 2) == 1;
      if (nxt != 0) m_run = 0; else m_run++;
      e_tick = (nxt == 0) && (m_run > 0) && ((m_run % CLK_IN) == 0);
    end
  endtask

  task automatic step(output int err);
    @(posedge i_Clk);
    model_edge();
    #1;
    err = (o_Hours !== 5'(m_secday / 3600) || o_Minutes !== 6'((m_secday / 60) % 60) ||
           o_Seconds !== 6'(m_secday % 60) || o_Tick_1Hz !== e_tick ||
           o_Tick_Scan !== e_scan || o_Blink !== e_blink || o_Setting !== e_setting) ? 1 : 0;
  endtask

  task automatic run(input int n, output int ticks, output int errs);
    int e;
    ticks = 0; errs = 0;
    repeat (n) begin
      step(e);
      errs += e;
      if (o_Tick_1Hz === 1'b1) ticks++;
    end
  endtask

  task automatic pulse_inc(output int errs);
    int t;
    i_Inc = 1'b1;
    run(1, t, errs);
    i_Inc = 1'b0;
  endtask

  task automatic test_reset();
    int t, e;
    i_Reset = 1'b1; i_Set_Mode = 2'b00; i_Inc = 1'b0;
    run(3, t, e);
    total++;
    if ({o_Hours, o_Minutes, o_Seconds, o_Tick_1Hz, o_Tick_Scan, o_Blink, o_Setting} !== 21'h0) begin
      bad++;
      $display("FAIL reset_state: got %0d:%0d:%0d t1=%b ts=%b bl=%b set=%b want all 0",
               o_Hours, o_Minutes, o_Seconds, o_Tick_1Hz, o_Tick_Scan, o_Blink, o_Setting);
    end
    i_Reset = 1'b0;
  endtask

  task automatic test_free_run();
    int q_tick[$];
    int e, errs, scans, scan_off, toggles, blink_off;
    logic prev;
    errs = 0; scans = 0; scan_off = 0; toggles = 0; blink_off = 0; prev = o_Blink;
    for (int n = 1; n <= 3001; n++) begin
      i_Inc = 1'($urandom_range(0, 1));
      step(e); errs += e;
      if (o_Tick_1Hz === 1'b1) q_tick.push_back(n);
      if (o_Tick_Scan === 1'b1) begin scans++; if (n % SCAN_P != 0) scan_off++; end
      if (o_Blink !== prev) begin toggles++; if ((n - 1) % BLINK_P != 0) blink_off++; prev = o_Blink; end
    end
    i_Inc = 1'b0;
    total++;
    if (q_tick.size() != 3 || q_tick[0] != 1000 || q_tick[1] != 2000 || q_tick[2] != 3000) begin
      bad++;
      $display("FAIL run_tick_cycles: got %0d ticks first=%0d want 3 at 1000/2000/3000",
               q_tick.size(), (q_tick.size() > 0) ? q_tick[0] : -1);
    end
    total++;
    if (o_Seconds !== 6'd3) begin bad++; $display("FAIL run_seconds: got %0d want 3", o_Seconds); end
    total++;
    if (scans != 300 || scan_off != 0) begin
      bad++; $display("FAIL run_scan: got %0d pulses (%0d misplaced) want 300 (0)", scans, scan_off);
    end
    total++;
    if (toggles != 12 || blink_off != 0) begin
      bad++; $display("FAIL run_blink: got %0d toggles (%0d misplaced) want 12 (0)", toggles, blink_off);
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL run_model: got %0d mismatching cycles want 0", errs); end
  endtask

  task automatic test_set_hours();
    int t, e, errs, ticks, guard;
    errs = 0; ticks = 0;
    i_Set_Mode = 2'b01;
    run(1, t, e); errs += e;
    total++;
    if (o_Setting !== 1'b1 || o_Seconds !== 6'd0) begin
      bad++; $display("FAIL sethr_entry: got set=%b sec=%0d want 1 0", o_Setting, o_Seconds);
    end
    guard = 0;
    while (o_Hours !== 5'd22 && guard < 30) begin pulse_inc(e); errs += e; guard++; end
    // two back-to-back pulses, then three with random gaps
    i_Inc = 1'b1; run(2, t, e); errs += e; ticks += t; i_Inc = 1'b0;
    repeat (3) begin
      run($urandom_range(0, 3), t, e); errs += e; ticks += t;
      pulse_inc(e); errs += e;
    end
    total++;
    if (o_Hours !== 5'd3 || o_Minutes !== 6'd0) begin
      bad++; $display("FAIL sethr_wrap: got %0d:%0d want 3:0", o_Hours, o_Minutes);
    end
    total++;
    if (ticks != 0) begin bad++; $display("FAIL sethr_silent: got %0d ticks want 0", ticks); end
    total++;
    if (errs != 0) begin bad++; $display("FAIL sethr_model: got %0d mismatching cycles want 0", errs); end
  endtask

  task automatic test_set_minutes();
    int t, e, errs, guard;
    errs = 0;
    guard = 0;
    while (o_Hours !== 5'd10 && guard < 30) begin pulse_inc(e); errs += e; guard++; end
    i_Set_Mode = 2'b10; run(1, t, e); errs += e;
    guard = 0;
    while (o_Minutes !== 6'd59 && guard < 70) begin pulse_inc(e); errs += e; guard++; end
    i_Set_Mode = 2'b00;
    guard = 0;
    while (o_Seconds !== 6'd4 && guard < 5000) begin step(e); errs += e; guard++; end
    total++;
    if (o_Hours !== 5'd10 || o_Minutes !== 6'd59 || o_Seconds !== 6'd4) begin
      bad++; $display("FAIL setmin_prep: got %0d:%0d:%0d want 10:59:4", o_Hours, o_Minutes, o_Seconds);
    end
    i_Set_Mode = 2'b10; run(1, t, e); errs += e;
    total++;
    if (o_Seconds !== 6'd0 || o_Minutes !== 6'd59 || o_Setting !== 1'b1) begin
      bad++; $display("FAIL setmin_entry: got min=%0d sec=%0d set=%b want 59 0 1", o_Minutes, o_Seconds, o_Setting);
    end
    pulse_inc(e); errs += e;
    total++;
    if (o_Minutes !== 6'd0 || o_Hours !== 5'd10) begin
      bad++; $display("FAIL setmin_nocarry: got %0d:%0d want 10:0", o_Hours, o_Minutes);
    end
    // increment on a mode-change edge lands on the previous state's field
    i_Set_Mode = 2'b01; pulse_inc(e); errs += e;
    i_Set_Mode = 2'b00; pulse_inc(e); errs += e;
    i_Set_Mode = 2'b10; pulse_inc(e); errs += e;
    total++;
    if (o_Hours !== 5'd11 || o_Minutes !== 6'd1) begin
      bad++; $display("FAIL inc_on_switch: got %0d:%0d want 11:1", o_Hours, o_Minutes);
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL setmin_model: got %0d mismatching cycles want 0", errs); end
  endtask

  task automatic test_collision();
    int t, e, errs, guard;
    errs = 0;
    guard = 0;
    while (o_Minutes !== 6'd59 && guard < 70) begin pulse_inc(e); errs += e; guard++; end
    i_Set_Mode = 2'b00;
    guard = 0;
    while (!(o_Tick_1Hz === 1'b1 && o_Seconds === 6'd3) && guard < 5000) begin step(e); errs += e; guard++; end
    total++;
    if (o_Tick_1Hz !== 1'b1) begin bad++; $display("FAIL coll_wait: got no tick in %0d cycles want tick", guard); end
    i_Set_Mode = 2'b01; run(1, t, e); errs += e;
    total++;
    if (o_Hours !== 5'd11 || o_Minutes !== 6'd59 || o_Seconds !== 6'd0) begin
      bad++; $display("FAIL collision: got %0d:%0d:%0d want 11:59:0", o_Hours, o_Minutes, o_Seconds);
    end
    run(1500, t, e); errs += e;
    total++;
    if (t != 0 || errs != 0) begin
      bad++; $display("FAIL coll_hold: got %0d ticks %0d mismatches want 0 0", t, errs);
    end
  endtask

  task automatic test_rollover();
    int e, errs, guard, ticks, cyc;
    errs = 0;
    guard = 0;
    while (o_Hours !== 5'd23 && guard < 30) begin pulse_inc(e); errs += e; guard++; end
    i_Set_Mode = 2'b00;
    ticks = 0; cyc = 0;
    while (ticks < 60 && cyc < 61000) begin
      step(e); errs += e; cyc++;
      if (o_Tick_1Hz === 1'b1) ticks++;
    end
    total++;
    if (ticks != 60 || cyc != 60000) begin
      bad++; $display("FAIL roll_timing: got %0d ticks in %0d cycles want 60 in 60000", ticks, cyc);
    end
    total++;
    if (o_Hours !== 5'd23 || o_Minutes !== 6'd59 || o_Seconds !== 6'd59) begin
      bad++; $display("FAIL roll_pre: got %0d:%0d:%0d want 23:59:59", o_Hours, o_Minutes, o_Seconds);
    end
    step(e); errs += e;
    total++;
    if (o_Hours !== 5'd0 || o_Minutes !== 6'd0 || o_Seconds !== 6'd0) begin
      bad++; $display("FAIL roll_edge: got %0d:%0d:%0d want 0:0:0", o_Hours, o_Minutes, o_Seconds);
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL roll_model: got %0d mismatching cycles want 0", errs); end
  endtask

  task automatic test_reset_mid_set();
    int t, e, errs, guard, n;
    errs = 0;
    i_Set_Mode = 2'b10; run(1, t, e); errs += e;
    guard = 0;
    while (o_Minutes !== 6'd42 && guard < 70) begin pulse_inc(e); errs += e; guard++; end
    total++;
    if (o_Minutes !== 6'd42) begin bad++; $display("FAIL rst_prep: got %0d want 42", o_Minutes); end
    i_Reset = 1'b1; run(1, t, e); errs += e;
    i_Reset = 1'b0; i_Set_Mode = 2'b00;
    total++;
    if ({o_Hours, o_Minutes, o_Seconds, o_Tick_1Hz, o_Tick_Scan, o_Blink, o_Setting} !== 21'h0) begin
      bad++;
      $display("FAIL rst_mid: got %0d:%0d:%0d t1=%b ts=%b bl=%b set=%b want all 0",
               o_Hours, o_Minutes, o_Seconds, o_Tick_1Hz, o_Tick_Scan, o_Blink, o_Setting);
    end
    n = 0;
    while (n < 1100) begin
      step(e); errs += e; n++;
      if (o_Tick_1Hz === 1'b1) break;
    end
    total++;
    if (n != 1000) begin bad++; $display("FAIL rst_first_tick: got cycle %0d want 1000", n); end
    total++;
    if (errs != 0) begin bad++; $display("FAIL rst_model: got %0d mismatching cycles want 0", errs); end
  endtask

  task automatic test_back_to_back();
    int e, errs;
    errs = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) i_Set_Mode = 2'($urandom_range(0, 3));
      i_Inc = ($urandom_range(0, 2) == 0);
      step(e); errs += e;
    end
    i_Inc = 1'b0;
    total++;
    if (errs != 0) begin bad++; $display("FAIL random_model: got %0d mismatching cycles want 0", errs); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_set_hours();
    test_set_minutes();
    test_collision();
    test_rollover();
    test_reset_mid_set();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
